// File: rtl/dmem_hs.sv
// dmem_hs: single-port 32-bit data memory with a request/ready handshake and
// a fixed access latency. Supports word and little-endian byte loads/stores;
// word addresses beyond DEPTH complete with err=1, rd=0 and no write.
//
// Ports:
//   clk    - single clock, all state updates on the rising edge
//   reset  - synchronous, active-high; does not clear memory contents
//   req    - access request valid (sampled in IDLE and in the DONE cycle)
//   we     - 1 = store, 0 = load
//   bmode  - 1 = byte access, 0 = word access
//   a      - byte address (word index a[31:2], byte lane a[1:0])
//   wd     - store data (byte stores use wd[7:0])
//   rd     - load data, held until the next completion or reset
//   ready  - one-cycle completion pulse
//   busy   - access in progress (WAIT or DONE)
//   err    - out-of-range flag, valid with ready and held like rd
module dmem_hs #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        bmode,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] wd_q;
  logic        we_q;
  logic        bmode_q;

  logic [31:0] mem [DEPTH];

  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic          oor;
  logic          fire;
  logic [31:0]   word;
  logic [31:0]   shifted;

  always_comb begin
    idx     = a_q[IW+1:2];
    lane    = a_q[1:0];
    oor     = (a_q[31:IW+2] != '0);
    fire    = (state == WAIT) && (cnt == '0);
    word    = mem[idx];
    shifted = word >> {lane, 3'b000};
  end

  // Stores commit on the edge that enters DONE; reset suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && fire && we_q && !oor) begin
      if (bmode_q)
        mem[idx][{lane, 3'b000} +: 8] <= wd_q[7:0];
      else
        mem[idx] <= wd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
      rd    <= '0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        // The edge leaving DONE is the first IDLE edge: a request pending
        // there is accepted directly, giving LATENCY+1 spacing under
        // back-to-back requests.
        IDLE, DONE: begin
          if (req) begin
            a_q     <= a;
            wd_q    <= wd;
            we_q    <= we;
            bmode_q <= bmode;
            cnt     <= 4'(LATENCY - 1);
            state   <= WAIT;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= DONE;
            ready <= 1'b1;
            err   <= oor;
            if (we_q || oor)
              rd <= '0;
            else if (bmode_q)
              rd <= {24'b0, shifted[7:0]};
            else
              rd <= word;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
